// File: rtl/sram_lsu_pkg.sv
// Shared encodings and helpers for the SRAM load/store unit.
package sram_lsu_pkg;

  localparam int WORD_ADDR_BITS_DEF = 14;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } lsu_state_t;

  // True when the access cannot be issued: illegal size or misaligned offset.
  function automatic logic access_bad(input logic [1:0] size, input logic [1:0] offset);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = offset[0];
      SZ_WORD: bad = (offset != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] offset);
    logic [3:0] mask;
    mask = 4'b0000;
    case (size)
      SZ_BYTE: mask = 4'b0001 << offset;
      SZ_HALF: mask = 4'b0011 << offset;
      SZ_WORD: mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

  // Stores replicate the right-aligned datum across every lane it could occupy.
  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] data;
    data = wdata;
    case (size)
      SZ_BYTE: data = {4{wdata[7:0]}};
      SZ_HALF: data = {2{wdata[15:0]}};
      default: data = wdata;
    endcase
    return data;
  endfunction

endpackage

// File: rtl/sram_lsu_extract.sv
// Picks the addressed lane(s) of an SRAM word and sign/zero-extends to 32 bits.
module sram_lsu_extract
  import sram_lsu_pkg::*;
(
  input  logic [31:0] data,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = data[{offset, 3'b000} +: 8];
    half_sel = offset[1] ? data[31:16] : data[15:0];
    result   = '0;
    case (size)
      SZ_BYTE: result = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
      SZ_HALF: result = {{16{~is_unsigned & half_sel[15]}}, half_sel};
      SZ_WORD: result = data;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/sram_lsu.sv
// Single-outstanding load/store unit in front of a synchronous 32-bit SRAM.
module sram_lsu
  import sram_lsu_pkg::*;
#(
  parameter int WORD_ADDR_BITS = WORD_ADDR_BITS_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [1:0]                req_size,
  input  logic                      req_unsigned,
  input  logic [WORD_ADDR_BITS+1:0] req_addr,
  input  logic [31:0]               req_wdata,
  output logic                      resp_valid,
  output logic                      resp_err,
  output logic [31:0]               resp_rdata,
  output logic [WORD_ADDR_BITS-1:0] sram_addr,
  output logic                      sram_read,
  output logic [3:0]                sram_write,
  output logic [31:0]               sram_DI,
  input  logic [31:0]               sram_DO
);

  lsu_state_t                state_reg;
  logic                      we_reg;
  logic [1:0]                size_reg;
  logic                      unsigned_reg;
  logic [WORD_ADDR_BITS+1:0] addr_reg;
  logic [31:0]               wdata_reg;
  logic                      err_reg;
  logic [31:0]               rdata_reg;
  logic [31:0]               load_value;

  sram_lsu_extract u_extract (
    .data        (sram_DO),
    .offset      (addr_reg[1:0]),
    .size        (size_reg),
    .is_unsigned (unsigned_reg),
    .result      (load_value)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      we_reg       <= 1'b0;
      size_reg     <= SZ_BYTE;
      unsigned_reg <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      err_reg      <= 1'b0;
      rdata_reg    <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (req_valid) begin
            we_reg       <= req_we;
            size_reg     <= req_size;
            unsigned_reg <= req_unsigned;
            addr_reg     <= req_addr;
            wdata_reg    <= req_wdata;
            err_reg      <= access_bad(req_size, req_addr[1:0]);
            if (access_bad(req_size, req_addr[1:0])) begin
              rdata_reg <= '0;
              state_reg <= ST_DONE;
            end else begin
              state_reg <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          // Stores complete straight away; loads wait for the SRAM's registered output.
          if (we_reg) begin
            rdata_reg <= '0;
            state_reg <= ST_DONE;
          end else begin
            state_reg <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          rdata_reg <= load_value;
          state_reg <= ST_DONE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Strobes decode from the state register, so an async reset drops them at once.
  assign req_ready  = (state_reg == ST_IDLE);
  assign resp_valid = (state_reg == ST_DONE);
  assign resp_err   = (state_reg == ST_DONE) && err_reg;
  assign resp_rdata = rdata_reg;
  assign sram_addr  = addr_reg[WORD_ADDR_BITS+1:2];
  assign sram_DI    = store_data(size_reg, wdata_reg);
  assign sram_read  = (state_reg == ST_ISSUE) && !we_reg;
  assign sram_write = ((state_reg == ST_ISSUE) && we_reg) ? lane_mask(size_reg, addr_reg[1:0]) : 4'b0000;

endmodule

// File: tb/tb_sram_lsu.sv
// Directed table-driven bench for sram_lsu with a behavioural synchronous SRAM.
module tb_sram_lsu;

  localparam int WAB = 14;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           req_valid = 1'b0;
  logic           req_ready;
  logic           req_we = 1'b0;
  logic [1:0]     req_size = 2'b00;
  logic           req_unsigned = 1'b0;
  logic [WAB+1:0] req_addr = '0;
  logic [31:0]    req_wdata = '0;
  logic           resp_valid;
  logic           resp_err;
  logic [31:0]    resp_rdata;
  logic [WAB-1:0] sram_addr;
  logic           sram_read;
  logic [3:0]     sram_write;
  logic [31:0]    sram_DI;
  logic [31:0]    sram_DO = '0;

  logic [31:0] mem [0:(1<<WAB)-1];

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  sram_lsu #(.WORD_ADDR_BITS(WAB)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_err     (resp_err),
    .resp_rdata   (resp_rdata),
    .sram_addr    (sram_addr),
    .sram_read    (sram_read),
    .sram_write   (sram_write),
    .sram_DI      (sram_DI),
    .sram_DO      (sram_DO)
  );

  always @(posedge clk) begin
    if (sram_read) sram_DO <= mem[sram_addr];
    for (int i = 0; i < 4; i++)
      if (sram_write[i]) mem[sram_addr][8*i +: 8] <= sram_DI[8*i +: 8];
  end

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    logic [3:0]  wmask;
    logic [31:0] di;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  task automatic run_vec(input vec_t v);
    int   lat, nrd, nwr, exp_lat;
    logic got;
    logic [3:0] wm;
    logic [31:0] di;
    logic [WAB-1:0] sa;
    @(negedge clk);
    check({v.name, " ready_before"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = v.we; req_size = v.size; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; nrd = 0; nwr = 0; got = 1'b0; wm = '0; di = '0; sa = '0;
    for (int k = 1; k <= 8 && !got; k++) begin
      @(negedge clk);
      if (sram_read) begin nrd++; sa = sram_addr; end
      if (sram_write != 4'b0000) begin nwr++; wm = sram_write; di = sram_DI; sa = sram_addr; end
      if (resp_valid) begin
        got = 1'b1;
        lat = k;
        check({v.name, " resp_err"}, {31'd0, resp_err}, {31'd0, v.err});
        check({v.name, " resp_rdata"}, resp_rdata, v.rdata);
        check({v.name, " ready_in_done"}, {31'd0, req_ready}, 32'd0);
      end
    end
    exp_lat = v.err ? 1 : (v.we ? 2 : 3);
    check({v.name, " latency"}, lat, exp_lat);
    check({v.name, " read_strobes"}, nrd, (!v.err && !v.we) ? 1 : 0);
    check({v.name, " write_strobes"}, nwr, (!v.err && v.we) ? 1 : 0);
    if (!v.err) check({v.name, " sram_addr"}, {18'd0, sa}, {18'd0, v.addr[15:2]});
    if (!v.err && v.we) begin
      check({v.name, " sram_write"}, {28'd0, wm}, {28'd0, v.wmask});
      check({v.name, " sram_DI"}, di, v.di);
    end
    @(negedge clk);
    check({v.name, " valid_one_cycle"}, {31'd0, resp_valid}, 32'd0);
    check({v.name, " ready_after"}, {31'd0, req_ready}, 32'd1);
    check({v.name, " rdata_hold"}, resp_rdata, v.rdata);
    $display("txn %-14s we=%0b size=%0d addr=%04h -> lat=%0d err=%0b rdata=%08h",
             v.name, v.we, v.size, v.addr, lat, resp_err, resp_rdata);
  endtask

  initial begin
    int stray;
    vec_t v;
    //            name           we size   uns  addr     wdata          err  rdata          mask     di
    vecs[0]  = '{"st_w_10",      1, 2'b10, 0, 16'h0010, 32'hDEADBEEF, 0, 32'h00000000, 4'b1111, 32'hDEADBEEF};
    vecs[1]  = '{"st_b_13",      1, 2'b00, 0, 16'h0013, 32'h000000A5, 0, 32'h00000000, 4'b1000, 32'hA5A5A5A5};
    vecs[2]  = '{"ld_bs_13",     0, 2'b00, 0, 16'h0013, 32'h0,        0, 32'hFFFFFFA5, 4'b0000, 32'h0};
    vecs[3]  = '{"ld_bu_13",     0, 2'b00, 1, 16'h0013, 32'h0,        0, 32'h000000A5, 4'b0000, 32'h0};
    vecs[4]  = '{"st_w_20",      1, 2'b10, 0, 16'h0020, 32'h80017F02, 0, 32'h00000000, 4'b1111, 32'h80017F02};
    vecs[5]  = '{"ld_hs_22",     0, 2'b01, 0, 16'h0022, 32'h0,        0, 32'hFFFF8001, 4'b0000, 32'h0};
    vecs[6]  = '{"ld_hu_22",     0, 2'b01, 1, 16'h0022, 32'h0,        0, 32'h00008001, 4'b0000, 32'h0};
    vecs[7]  = '{"ld_hs_20",     0, 2'b01, 0, 16'h0020, 32'h0,        0, 32'h00007F02, 4'b0000, 32'h0};
    vecs[8]  = '{"ld_bu_21",     0, 2'b00, 1, 16'h0021, 32'h0,        0, 32'h0000007F, 4'b0000, 32'h0};
    vecs[9]  = '{"ld_bs_23",     0, 2'b00, 0, 16'h0023, 32'h0,        0, 32'hFFFFFF80, 4'b0000, 32'h0};
    vecs[10] = '{"st_h_22",      1, 2'b01, 0, 16'h0022, 32'h1234CAFE, 0, 32'h00000000, 4'b1100, 32'hCAFECAFE};
    vecs[11] = '{"ld_w_20",      0, 2'b10, 0, 16'h0020, 32'h0,        0, 32'hCAFE7F02, 4'b0000, 32'h0};
    vecs[12] = '{"err_w_21",     0, 2'b10, 0, 16'h0021, 32'h0,        1, 32'h00000000, 4'b0000, 32'h0};
    vecs[13] = '{"err_h_03",     0, 2'b01, 0, 16'h0003, 32'h0,        1, 32'h00000000, 4'b0000, 32'h0};
    vecs[14] = '{"err_sz11",     1, 2'b11, 0, 16'h0008, 32'h12345678, 1, 32'h00000000, 4'b0000, 32'h0};
    vecs[15] = '{"st_w_40",      1, 2'b10, 0, 16'h0040, 32'h5A5A5A5A, 0, 32'h00000000, 4'b1111, 32'h5A5A5A5A};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst ready", {31'd0, req_ready}, 32'd1);
    check("rst resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst resp_err", {31'd0, resp_err}, 32'd0);
    check("rst resp_rdata", resp_rdata, 32'd0);
    check("rst sram_read", {31'd0, sram_read}, 32'd0);
    check("rst sram_write", {28'd0, sram_write}, 32'd0);
    check("rst sram_addr", {18'd0, sram_addr}, 32'd0);
    check("rst sram_DI", sram_DI, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) run_vec(vecs[i]);

    // Load result survives an intervening store? No: a store clears it; a load then holds.
    v = '{"ld_w_10", 0, 2'b10, 0, 16'h0010, 32'h0, 0, 32'hA5ADBEEF, 4'b0000, 32'h0};
    run_vec(v);
    repeat (3) @(negedge clk);
    check("rdata_hold_idle", resp_rdata, 32'hA5ADBEEF);

    // Reset asserted while a store sits in ISSUE
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 16'h0040; req_wdata = 32'h11111111;
    @(posedge clk);
    #1 req_valid = 1'b0;
    #1 check("abort issue_write", {28'd0, sram_write}, 32'h0000000F);
    rst = 1'b1;
    #1;
    check("abort write_drop", {28'd0, sram_write}, 32'd0);
    check("abort ready", {31'd0, req_ready}, 32'd1);
    check("abort resp_valid", {31'd0, resp_valid}, 32'd0);
    check("abort sram_DI", sram_DI, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    stray = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (resp_valid) stray++;
    end
    check("abort no_response", stray, 0);
    v = '{"ld_w_40_post", 0, 2'b10, 0, 16'h0040, 32'h0, 0, 32'h5A5A5A5A, 4'b0000, 32'h0};
    run_vec(v);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
